syn_harness_ctrl: RTL and testbench

Frame sequencer for synthesis-harness test setups. It assembles a serial bit stream into an IN_WIDTH-bit operand for the datapath under test and issues a one-cycle launch strobe. It then waits a fixed pipeline latency, captures the OUT_WIDTH-bit result and streams it back out serially. It sits between the serial pin-level harness and the arithmetic unit, so a single start request runs one complete operand/result transaction.

---
 rtl/syn_harness_ctrl.sv | 118 +++++++++++
 tb/tb_syn_harness_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_harness_ctrl.sv
// rtl/syn_harness_ctrl.sv - serial operand/result frame sequencer for a synthesis-harness datapath
// Optional build macro: SYN_HARNESS_CTRL_PARITY_EN (appends an XOR parity bit to the result stream)
module syn_harness_ctrl #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    output logic                 busy,
    output logic [IN_WIDTH-1:0]  dut_in,
    output logic                 dut_in_vld,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 bit_out,
    output logic                 bit_out_vld,
    output logic                 done
);

    localparam int MAX_A = (IN_WIDTH > OUT_WIDTH + 1) ? IN_WIDTH : OUT_WIDTH + 1;
    localparam int MAX_V = (MAX_A > LATENCY) ? MAX_A : LATENCY;
    localparam int CW    = $clog2(MAX_V) + 1;

`ifdef SYN_HARNESS_CTRL_PARITY_EN
    localparam int SO_W = OUT_WIDTH + 1;
`else
    localparam int SO_W = OUT_WIDTH;
`endif

    localparam logic [CW-1:0] IN_LAST  = CW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(SO_W - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_LAUNCH,
        S_WAIT,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [IN_WIDTH-1:0] r_dut_in;
    logic [SO_W-1:0]   r_sout;
    logic              w_capture;
    logic [SO_W-1:0]   w_load;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_SHIFT_IN;
            S_SHIFT_IN:  if (r_cnt == IN_LAST) w_next = S_LAUNCH;
            S_LAUNCH:    w_next = (LATENCY == 0) ? S_SHIFT_OUT : S_WAIT;
            S_WAIT:      if (r_cnt == LAT_LAST) w_next = S_SHIFT_OUT;
            S_SHIFT_OUT: if (r_cnt == OUT_LAST) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Result is captured on whichever edge enters SHIFT_OUT
    assign w_capture = (r_state != S_SHIFT_OUT) && (w_next == S_SHIFT_OUT);

`ifdef SYN_HARNESS_CTRL_PARITY_EN
    assign w_load = {dut_out, ^dut_out};
`else
    assign w_load = dut_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // One shared counter, cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != w_next) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_in <= '0;
        end else if (r_state == S_SHIFT_IN) begin
            r_dut_in <= (r_dut_in << 1) | IN_WIDTH'(bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sout <= '0;
        end else if (w_capture) begin
            r_sout <= w_load;
        end else if (r_state == S_SHIFT_OUT) begin
            r_sout <= r_sout << 1;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign dut_in      = r_dut_in;
    assign dut_in_vld  = (r_state == S_LAUNCH);
    assign bit_out_vld = (r_state == S_SHIFT_OUT);
    assign bit_out     = bit_out_vld & r_sout[SO_W-1];
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_syn_harness_ctrl.sv
// tb/tb_syn_harness_ctrl.sv - directed-vector bench for syn_harness_ctrl (default and W4/L0 instances)
module tb_syn_harness_ctrl;

`ifdef SYN_HARNESS_CTRL_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_a = 1'b0, bit_in_a = 1'b0;
    logic       busy_a, dut_in_vld_a, bit_out_a, bit_out_vld_a, done_a;
    logic [7:0] dut_in_a, dut_out_a, dly1_a, dly2_a;

    logic       start_b = 1'b0, bit_in_b = 1'b0;
    logic       busy_b, dut_in_vld_b, bit_out_b, bit_out_vld_b, done_b;
    logic [3:0] dut_in_b;
    logic [3:0] dut_out_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    syn_harness_ctrl #(.IN_WIDTH(8), .OUT_WIDTH(8), .LATENCY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bit_in(bit_in_a),
        .busy(busy_a), .dut_in(dut_in_a), .dut_in_vld(dut_in_vld_a),
        .dut_out(dut_out_a), .bit_out(bit_out_a), .bit_out_vld(bit_out_vld_a),
        .done(done_a)
    );

    syn_harness_ctrl #(.IN_WIDTH(4), .OUT_WIDTH(4), .LATENCY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bit_in(bit_in_b),
        .busy(busy_b), .dut_in(dut_in_b), .dut_in_vld(dut_in_vld_b),
        .dut_out(dut_out_b), .bit_out(bit_out_b), .bit_out_vld(bit_out_vld_b),
        .done(done_b)
    );

    // Loopback datapath model: dut_out is dut_in delayed two cycles
    always @(posedge clk) begin
        dly1_a <= dut_in_a;
        dly2_a <= dly1_a;
    end
    assign dut_out_a = dly2_a;
    assign dut_out_b = 4'h3;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame_a(input logic [7:0] v);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in_a = v[7-i];
            step();
        end
        bit_in_a = 1'b0;
        n_vec++;
        if (dut_in_a !== v || dut_in_vld_a !== 1'b1) begin
            n_err++;
            $display("FAIL launch: dut_in=%h vld=%b, required %h vld=1", dut_in_a, dut_in_vld_a, v);
        end
        step();
        n_vec++;
        if (dut_in_vld_a !== 1'b0 || busy_a !== 1'b1 || bit_out_vld_a !== 1'b0) begin
            n_err++;
            $display("FAIL wait_state: vld=%b busy=%b bov=%b, required 0 1 0", dut_in_vld_a, busy_a, bit_out_vld_a);
        end
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            n_vec++;
            if (bit_out_a !== v[7-k] || bit_out_vld_a !== 1'b1) begin
                n_err++;
                $display("FAIL bit_out[%0d]: bit=%b vld=%b, required %b vld=1", k, bit_out_a, bit_out_vld_a, v[7-k]);
            end
        end
        if (PX == 1) begin
            step();
            n_vec++;
            if (bit_out_a !== (^v) || bit_out_vld_a !== 1'b1) begin
                n_err++;
                $display("FAIL parity_a: bit=%b vld=%b, required %b vld=1", bit_out_a, bit_out_vld_a, ^v);
            end
        end
        step();
        n_vec++;
        if (done_a !== 1'b1 || busy_a !== 1'b1 || bit_out_vld_a !== 1'b0) begin
            n_err++;
            $display("FAIL done_a: done=%b busy=%b bov=%b, required 1 1 0", done_a, busy_a, bit_out_vld_a);
        end
        step();
        n_vec++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL end_a: busy=%b done=%b, required 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy_a !== 1'b0 || dut_in_a !== 8'h00 || dut_in_vld_a !== 1'b0 ||
            bit_out_a !== 1'b0 || bit_out_vld_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: busy=%b dut_in=%h vld=%b bo=%b bov=%b done=%b, required all 0",
                     busy_a, dut_in_a, dut_in_vld_a, bit_out_a, bit_out_vld_a, done_a);
        end
        n_vec++;
        if (busy_b !== 1'b0 || dut_in_b !== 4'h0 || dut_in_vld_b !== 1'b0 ||
            bit_out_b !== 1'b0 || bit_out_vld_b !== 1'b0 || done_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: busy=%b dut_in=%h vld=%b bo=%b bov=%b done=%b, required all 0",
                     busy_b, dut_in_b, dut_in_vld_b, bit_out_b, bit_out_vld_b, done_b);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_loopback;
        run_frame_a(8'hA5);
        run_frame_a(8'h5E);
    endtask

    task automatic test_zero_latency;
        logic [3:0] e;
        e = 4'h3;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_in_b = (i < 2);
            step();
        end
        bit_in_b = 1'b0;
        n_vec++;
        if (dut_in_b !== 4'hC || dut_in_vld_b !== 1'b1) begin
            n_err++;
            $display("FAIL launch_b: dut_in=%h vld=%b, required c vld=1", dut_in_b, dut_in_vld_b);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (bit_out_b !== e[3-k] || bit_out_vld_b !== 1'b1) begin
                n_err++;
                $display("FAIL bit_out_b[%0d]: bit=%b vld=%b, required %b vld=1", k, bit_out_b, bit_out_vld_b, e[3-k]);
            end
        end
        if (PX == 1) begin
            step();
            n_vec++;
            if (bit_out_b !== 1'b0 || bit_out_vld_b !== 1'b1) begin
                n_err++;
                $display("FAIL parity_b: bit=%b vld=%b, required 0 vld=1", bit_out_b, bit_out_vld_b);
            end
        end
        step();
        n_vec++;
        if (done_b !== 1'b1) begin
            n_err++;
            $display("FAIL done_b: done=%b, required 1", done_b);
        end
        step();
        n_vec++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            n_err++;
            $display("FAIL end_b: busy=%b done=%b, required 0 0", busy_b, done_b);
        end
    endtask

    task automatic test_start_held;
        int n;
        int ndone;
        int t;
        n = 0;
        ndone = 0;
        start_a = 1'b1;
        step();
        while (busy_a && n < 60) begin
            n++;
            if (done_a) ndone++;
            bit_in_a = 1'($urandom_range(0, 1));
            step();
        end
        n_vec++;
        if (n !== 20 + PX || ndone !== 1) begin
            n_err++;
            $display("FAIL held_busy_len: cycles=%0d dones=%0d, required %0d 1", n, ndone, 20 + PX);
        end
        step();
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL held_reaccept: busy=%b, required 1", busy_a);
        end
        start_a = 1'b0;
        t = 0;
        while (!done_a && t < 40) begin
            step();
            t++;
        end
        n_vec++;
        if (t >= 40) begin
            n_err++;
            $display("FAIL held_second_done: timeout after %0d cycles, required done", t);
        end
        step();
        n_vec++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL held_second_end: busy=%b, required 0", busy_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        int nd;
        nd = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in_a = 1'b1;
            step();
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy_a !== 1'b0 || dut_in_a !== 8'h00 || dut_in_vld_a !== 1'b0 ||
            bit_out_a !== 1'b0 || bit_out_vld_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b dut_in=%h vld=%b bo=%b bov=%b done=%b, required all 0",
                     busy_a, dut_in_a, dut_in_vld_a, bit_out_a, bit_out_vld_a, done_a);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done_a || busy_a) nd++;
        end
        n_vec++;
        if (nd !== 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: active cycles=%0d, required 0", nd);
        end
        run_frame_a(8'h3C);
    endtask

    task automatic test_idle_hold;
        int bad;
        bad = 0;
        start_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bit_in_a = 1'($urandom_range(0, 1));
            step();
            if (busy_a !== 1'b0 || dut_in_vld_a !== 1'b0 || bit_out_vld_a !== 1'b0 ||
                done_a !== 1'b0 || bit_out_a !== 1'b0 || dut_in_a !== 8'h3C) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL idle_hold: bad cycles=%0d dut_in=%h, required 0 and 3c", bad, dut_in_a);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_zero_latency();
        test_start_held();
        test_reset_mid_frame();
        test_idle_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
